// File: rtl/ib_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ib_dispatch_pkg
// Purpose  : Opcodes, instruction field positions and FSM encoding for dispatch.
// Revision : 1.0 - initial release
// ============================================================================
package ib_dispatch_pkg;

    localparam int c_TAG_W = 4;

    localparam logic [3:0] c_OP_MOV  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_JMP  = 4'h2;
    localparam logic [3:0] c_OP_LD   = 4'h3;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    localparam int c_OP_LSB = 12;
    localparam int c_RA_LSB = 8;
    localparam int c_RB_LSB = 4;
    localparam int c_RT_LSB = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    function automatic logic [3:0] f_field(input logic [15:0] inst, input int lsb);
        return inst[lsb +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ib_dispatch_regstat.sv
`default_nettype none
// ============================================================================
// Module   : ib_dispatch_regstat
// Purpose  : Register status table: two bypassed read ports, rename, CDB snoop.
// Revision : 1.0 - initial release
// ============================================================================
module ib_dispatch_regstat
    import ib_dispatch_pkg::*;
#(
    parameter int TAG_W = c_TAG_W,
    parameter int NREG  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       a_addr,
    output logic             a_busy,
    output logic [TAG_W-1:0] a_tag,
    output logic [15:0]      a_val,
    input  logic [3:0]       b_addr,
    output logic             b_busy,
    output logic [TAG_W-1:0] b_tag,
    output logic [15:0]      b_val,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [15:0]      cdb_data
);

    logic [NREG-1:0]  r_busy;
    logic [TAG_W-1:0] r_tag [NREG];
    logic [15:0]      r_val [NREG];

    // A rename on the same edge as the CDB result for the old tag keeps the new mapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
                r_val[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en && (wr_addr == 4'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= wr_tag;
                end else if (cdb_valid && r_busy[i] && (r_tag[i] == cdb_tag)) begin
                    r_busy[i] <= 1'b0;
                    r_val[i]  <= cdb_data;
                end
            end
        end
    end

    always_comb begin
        a_busy = r_busy[a_addr];
        a_tag  = r_tag[a_addr];
        a_val  = r_val[a_addr];
        if (r_busy[a_addr] && cdb_valid && (r_tag[a_addr] == cdb_tag)) begin
            a_busy = 1'b0;
            a_val  = cdb_data;
        end
        if (!a_busy) begin
            a_tag = '0;
        end
    end

    always_comb begin
        b_busy = r_busy[b_addr];
        b_tag  = r_tag[b_addr];
        b_val  = r_val[b_addr];
        if (r_busy[b_addr] && cdb_valid && (r_tag[b_addr] == cdb_tag)) begin
            b_busy = 1'b0;
            b_val  = cdb_data;
        end
        if (!b_busy) begin
            b_tag = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ib_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : ib_dispatch
// Purpose  : In-order dispatch from the instruction buffer into the ALU/load RSs.
// Revision : 1.0 - initial release
// ============================================================================
module ib_dispatch
    import ib_dispatch_pkg::*;
#(
    parameter int TAG_W = c_TAG_W,
    parameter int NREG  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ib_empty,
    input  logic [31:0]      ib_data_out,
    output logic             ib_pop,
    output logic             ib_flush,
    output logic             branch_taken,
    output logic [15:0]      branch_target,
    output logic             alu_valid,
    input  logic             alu_ready,
    input  logic [TAG_W-1:0] alu_tag,
    output logic             ld_valid,
    input  logic             ld_ready,
    input  logic [TAG_W-1:0] ld_tag,
    output logic [3:0]       rs_op,
    output logic             rs_a_busy,
    output logic             rs_b_busy,
    output logic [TAG_W-1:0] rs_a_tag,
    output logic [TAG_W-1:0] rs_b_tag,
    output logic [15:0]      rs_a_val,
    output logic [15:0]      rs_b_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [15:0]      cdb_data,
    output logic             halted
);

    state_t           r_state;
    logic             r_halted;
    logic [15:0]      w_inst;
    logic [3:0]       w_pc_hi, w_op, w_ra, w_rb, w_rt;
    logic             w_head, w_is_alu, w_is_ld, w_known;
    logic             w_fire_alu, w_fire_ld, w_jmp, w_halt, w_drop;
    logic             w_a_busy, w_b_busy;
    logic [TAG_W-1:0] w_a_tag, w_b_tag;
    logic [15:0]      w_a_val, w_b_val;
    logic             w_unused;

    assign w_inst   = ib_data_out[15:0];
    assign w_pc_hi  = ib_data_out[31:28];
    assign w_unused = &{1'b0, ib_data_out[27:16]};
    assign w_op     = f_field(w_inst, c_OP_LSB);
    assign w_ra     = f_field(w_inst, c_RA_LSB);
    assign w_rb     = f_field(w_inst, c_RB_LSB);
    assign w_rt     = f_field(w_inst, c_RT_LSB);

    // Gating on rst makes every combinational output drop the moment reset rises.
    assign w_head     = (r_state == ST_RUN) && !ib_empty && !rst;
    assign w_is_alu   = (w_op == c_OP_MOV) || (w_op == c_OP_ADD);
    assign w_is_ld    = (w_op == c_OP_LD);
    assign w_known    = w_is_alu || w_is_ld || (w_op == c_OP_JMP) || (w_op == c_OP_HALT);
    assign w_fire_alu = w_head && w_is_alu && alu_ready;
    assign w_fire_ld  = w_head && w_is_ld && ld_ready;
    assign w_jmp      = w_head && (w_op == c_OP_JMP);
    assign w_halt     = w_head && (w_op == c_OP_HALT);
    assign w_drop     = w_head && !w_known;

    assign ib_pop        = w_fire_alu || w_fire_ld || w_jmp || w_halt || w_drop;
    assign alu_valid     = w_fire_alu;
    assign ld_valid      = w_fire_ld;
    assign branch_taken  = w_jmp;
    assign ib_flush      = w_jmp;
    assign branch_target = w_jmp ? {w_pc_hi, w_inst[11:0]} : 16'h0000;
    assign halted        = r_halted;

    ib_dispatch_regstat #(
        .TAG_W (TAG_W),
        .NREG  (NREG)
    ) u_regstat (
        .clk       (clk),
        .rst       (rst),
        .a_addr    (w_ra),
        .a_busy    (w_a_busy),
        .a_tag     (w_a_tag),
        .a_val     (w_a_val),
        .b_addr    (w_rb),
        .b_busy    (w_b_busy),
        .b_tag     (w_b_tag),
        .b_val     (w_b_val),
        .wr_en     (w_fire_alu || w_fire_ld),
        .wr_addr   (w_rt),
        .wr_tag    (w_fire_alu ? alu_tag : ld_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always_comb begin
        rs_op     = 4'h0;
        rs_a_busy = 1'b0;
        rs_a_tag  = '0;
        rs_a_val  = 16'h0000;
        rs_b_busy = 1'b0;
        rs_b_tag  = '0;
        rs_b_val  = 16'h0000;
        if (w_fire_alu || w_fire_ld) begin
            rs_op = w_op;
            if (w_op == c_OP_MOV) begin
                rs_a_val = {8'h00, w_inst[11:4]};
            end else begin
                rs_a_busy = w_a_busy;
                rs_a_tag  = w_a_tag;
                rs_a_val  = w_a_val;
                rs_b_busy = w_b_busy;
                rs_b_tag  = w_b_tag;
                rs_b_val  = w_b_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_jmp) begin
                        r_state <= ST_REDIR;
                    end else if (w_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_REDIR: r_state <= ST_RUN;
                default:  r_state <= r_state;
            endcase
        end
    end

endmodule
`default_nettype wire
